// File: rtl/pci_blue_constants_pkg.sv
// Shared encodings for the pci_blue master sequencer: PCI command codes,
// completion status values and the one-hot master state encoding.
package pci_blue_constants;

    localparam logic [3:0] PCI_CMD_IO_READ   = 4'h2;
    localparam logic [3:0] PCI_CMD_IO_WRITE  = 4'h3;
    localparam logic [3:0] PCI_CMD_MEM_READ  = 4'h6;
    localparam logic [3:0] PCI_CMD_MEM_WRITE = 4'h7;
    localparam logic [3:0] PCI_CMD_CFG_READ  = 4'hA;
    localparam logic [3:0] PCI_CMD_CFG_WRITE = 4'hB;

    typedef enum logic [2:0] {
        ST_OK           = 3'd0,
        ST_RETRY        = 3'd1,
        ST_DISCONNECT   = 3'd2,
        ST_TARGET_ABORT = 3'd3,
        ST_MASTER_ABORT = 3'd4
    } done_status_e;

    typedef enum logic [5:0] {
        S_IDLE    = 6'b000001,
        S_REQ     = 6'b000010,
        S_ADDR    = 6'b000100,
        S_DATA    = 6'b001000,
        S_LAST    = 6'b010000,
        S_TURN_AR = 6'b100000
    } master_state_e;

    // PCI write-type commands all have bit 0 set.
    function automatic logic cmd_is_write(input logic [3:0] code);
        return code[0];
    endfunction

endpackage

// File: rtl/pci_blue_master_timers.sv
// Latency timer (loaded at the address phase, counts down to 0 and holds)
// and master-abort counter (cleared at the address phase, counts data cycles).
module pci_blue_master_timers #(
    parameter int ABORT_CYCLES = 5,
    parameter int LAT_WIDTH    = 8
) (
    input  logic                 pci_clk,
    input  logic                 pci_reset_comb,
    input  logic                 load_i,
    input  logic                 run_i,
    input  logic [LAT_WIDTH-1:0] lat_value_i,
    output logic                 lat_expired_o,
    output logic                 abort_expired_o
);

    localparam int AW = $clog2(ABORT_CYCLES + 1);
    localparam logic [AW-1:0] AB_LAST = AW'(ABORT_CYCLES - 1);
    localparam logic [AW-1:0] AB_SAT  = AW'(ABORT_CYCLES);

    logic [LAT_WIDTH-1:0] lat_q, lat_d;
    logic [AW-1:0]        ab_q, ab_d;

    always_comb begin
        lat_d = lat_q;
        ab_d  = ab_q;
        if (load_i) begin
            lat_d = lat_value_i;
            ab_d  = '0;
        end else if (run_i) begin
            if (lat_q != '0) begin
                lat_d = lat_q - LAT_WIDTH'(1);
            end
            if (ab_q != AB_SAT) begin
                ab_d = ab_q + AW'(1);
            end
        end
    end

    always_ff @(posedge pci_clk or posedge pci_reset_comb) begin
        if (pci_reset_comb) begin
            lat_q <= '0;
            ab_q  <= '0;
        end else begin
            lat_q <= lat_d;
            ab_q  <= ab_d;
        end
    end

    assign lat_expired_o   = (lat_q == '0);
    // Expiry is flagged in the ABORT_CYCLES-th data cycle after the address phase.
    assign abort_expired_o = (ab_q >= AB_LAST);

endmodule

// File: rtl/pci_blue_master_seq.sv
// PCI master sequencer: runs one burst command at a time on the bus and
// reports a completion status with the number of words moved.
//
// state   | meaning
// IDLE    | waiting for a command
// REQ     | REQ asserted, waiting for GNT on an idle bus
// ADDR    | address phase: FRAME, address and command driven
// DATA    | data phases with FRAME asserted
// LAST    | final data phase (FRAME released), or IRDY hold after termination
// TURN_AR | bus released, done pulse
module pci_blue_master_seq
    import pci_blue_constants::*;
#(
    parameter int ABORT_CYCLES = 5,
    parameter int LEN_WIDTH    = 5,
    parameter int LAT_WIDTH    = 8
) (
    input  logic                 pci_clk,
    input  logic                 pci_reset_comb,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3:0]           cmd_code,
    input  logic [31:0]          cmd_addr,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic [31:0]          wr_data,
    input  logic [3:0]           wr_byte_en_l,
    input  logic                 wr_valid,
    output logic                 wr_taken,
    output logic [31:0]          rd_data,
    output logic                 rd_strobe,
    output logic                 done,
    output logic [2:0]           done_status,
    output logic [LEN_WIDTH-1:0] done_count,
    output logic                 master_req_out,
    input  logic                 master_gnt_now,
    input  logic                 master_enable,
    input  logic [LAT_WIDTH-1:0] master_latency_value,
    input  logic                 pci_frame_in_prev,
    input  logic                 pci_irdy_in_prev,
    input  logic                 pci_devsel_in_prev,
    input  logic                 pci_trdy_in_prev,
    input  logic                 pci_stop_in_prev,
    input  logic [31:0]          pci_ad_in_prev,
    output logic                 pci_frame_out_next,
    output logic                 pci_irdy_out_next,
    output logic                 pci_frame_out_oe_next,
    output logic                 pci_irdy_out_oe_next,
    output logic                 pci_ad_out_oe_next,
    output logic                 pci_cbe_out_oe_next,
    output logic [31:0]          pci_ad_out_next,
    output logic [3:0]           pci_cbe_l_out_next
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_TWO = LEN_WIDTH'(2);

    master_state_e        state_q, state_d;
    done_status_e         status_q, status_d;
    logic [3:0]           cmd_q, cmd_d;
    logic [31:0]          addr_q, addr_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic                 term_q, term_d;
    logic                 dsel_q, dsel_d;

    logic                 tmr_load, tmr_run, lat_expired, abort_expired;
    logic                 is_wr, irdy_drv, xfer, term_hit;
    done_status_e         term_code;

    pci_blue_master_timers #(
        .ABORT_CYCLES (ABORT_CYCLES),
        .LAT_WIDTH    (LAT_WIDTH)
    ) u_timers (
        .pci_clk         (pci_clk),
        .pci_reset_comb  (pci_reset_comb),
        .load_i          (tmr_load),
        .run_i           (tmr_run),
        .lat_value_i     (master_latency_value),
        .lat_expired_o   (lat_expired),
        .abort_expired_o (abort_expired)
    );

    assign is_wr = cmd_is_write(cmd_q);
    // After a termination IRDY is held for one cycle regardless of write data.
    assign irdy_drv = term_q | ~is_wr | wr_valid;

    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        term_d    = term_q;
        dsel_d    = dsel_q;
        tmr_load  = 1'b0;
        tmr_run   = 1'b0;
        xfer      = 1'b0;
        term_hit  = 1'b0;
        term_code = ST_OK;

        cmd_ready             = 1'b0;
        wr_taken              = 1'b0;
        rd_strobe             = 1'b0;
        done                  = 1'b0;
        master_req_out        = 1'b0;
        pci_frame_out_next    = 1'b0;
        pci_irdy_out_next     = 1'b0;
        pci_frame_out_oe_next = 1'b0;
        pci_irdy_out_oe_next  = 1'b0;
        pci_ad_out_oe_next    = 1'b0;
        pci_cbe_out_oe_next   = 1'b0;
        pci_ad_out_next       = 32'h0;
        pci_cbe_l_out_next    = 4'h0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && master_enable && !pci_reset_comb) begin
                    cmd_ready = 1'b1;
                    cmd_d     = cmd_code;
                    addr_d    = cmd_addr;
                    rem_d     = (cmd_len == '0) ? LEN_ONE : cmd_len;
                    cnt_d     = '0;
                    status_d  = ST_OK;
                    term_d    = 1'b0;
                    state_d   = S_REQ;
                end
            end

            S_REQ: begin
                master_req_out = 1'b1;
                if (master_gnt_now && !pci_frame_in_prev && !pci_irdy_in_prev) begin
                    state_d = S_ADDR;
                end
            end

            S_ADDR: begin
                master_req_out        = (rem_q != LEN_ONE);
                pci_frame_out_next    = 1'b1;
                pci_frame_out_oe_next = 1'b1;
                pci_irdy_out_oe_next  = 1'b1;
                pci_ad_out_oe_next    = 1'b1;
                pci_cbe_out_oe_next   = 1'b1;
                pci_ad_out_next       = addr_q;
                pci_cbe_l_out_next    = cmd_q;
                tmr_load              = 1'b1;
                dsel_d                = 1'b0;
                state_d               = (rem_q == LEN_ONE) ? S_LAST : S_DATA;
            end

            S_DATA, S_LAST: begin
                master_req_out        = (state_q == S_DATA);
                pci_frame_out_next    = (state_q == S_DATA);
                pci_frame_out_oe_next = 1'b1;
                pci_irdy_out_oe_next  = 1'b1;
                pci_irdy_out_next     = irdy_drv;
                pci_cbe_out_oe_next   = 1'b1;
                pci_cbe_l_out_next    = is_wr ? wr_byte_en_l : 4'h0;
                pci_ad_out_oe_next    = is_wr;
                pci_ad_out_next       = is_wr ? wr_data : 32'h0;
                if (pci_devsel_in_prev) begin
                    dsel_d = 1'b1;
                end

                if (term_q) begin
                    state_d = S_TURN_AR;
                end else begin
                    tmr_run = 1'b1;
                    xfer    = irdy_drv & pci_trdy_in_prev;
                    if (xfer) begin
                        rem_d     = rem_q - LEN_ONE;
                        cnt_d     = cnt_q + LEN_ONE;
                        wr_taken  = is_wr;
                        rd_strobe = ~is_wr;
                    end

                    if (pci_stop_in_prev && !pci_devsel_in_prev) begin
                        term_hit  = 1'b1;
                        term_code = ST_TARGET_ABORT;
                    end else if (abort_expired && !dsel_q && !pci_devsel_in_prev) begin
                        term_hit  = 1'b1;
                        term_code = ST_MASTER_ABORT;
                    end else if (pci_stop_in_prev && !pci_trdy_in_prev) begin
                        term_hit  = 1'b1;
                        term_code = (cnt_q == '0) ? ST_RETRY : ST_DISCONNECT;
                    end else if (pci_stop_in_prev) begin
                        term_hit  = 1'b1;
                        term_code = ST_DISCONNECT;
                    end

                    if (term_hit) begin
                        status_d = term_code;
                        if (state_q == S_DATA) begin
                            state_d = S_LAST;
                            term_d  = 1'b1;
                        end else begin
                            state_d = S_TURN_AR;
                        end
                    end else if (xfer && (state_q == S_LAST || rem_q == LEN_ONE)) begin
                        status_d = ST_OK;
                        state_d  = S_TURN_AR;
                    end else if (state_q == S_DATA &&
                                 ((xfer && rem_q == LEN_TWO) ||
                                  (lat_expired && !master_gnt_now))) begin
                        state_d = S_LAST;
                    end
                end
            end

            S_TURN_AR: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pci_clk or posedge pci_reset_comb) begin
        if (pci_reset_comb) begin
            state_q  <= S_IDLE;
            status_q <= ST_OK;
            cmd_q    <= 4'h0;
            addr_q   <= 32'h0;
            rem_q    <= '0;
            cnt_q    <= '0;
            term_q   <= 1'b0;
            dsel_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            term_q   <= term_d;
            dsel_q   <= dsel_d;
        end
    end

    assign rd_data     = rd_strobe ? pci_ad_in_prev : 32'h0;
    assign done_status = done ? status_q : 3'd0;
    assign done_count  = done ? cnt_q : '0;

endmodule

// File: tb/tb_pci_blue_master_seq.sv
// Directed bench for pci_blue_master_seq: a simple target model answers
// DEVSEL/TRDY/STOP per burst and the completion reports are compared.
module tb_pci_blue_master_seq;
    import pci_blue_constants::*;

    localparam int LW = 5;
    localparam int TW = 8;

    logic          pci_clk = 1'b0;
    logic          pci_reset_comb;
    logic          cmd_valid, cmd_ready;
    logic [3:0]    cmd_code;
    logic [31:0]   cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [31:0]   wr_data;
    logic [3:0]    wr_byte_en_l;
    logic          wr_valid, wr_taken;
    logic [31:0]   rd_data;
    logic          rd_strobe, done;
    logic [2:0]    done_status;
    logic [LW-1:0] done_count;
    logic          master_req_out, master_gnt_now, master_enable;
    logic [TW-1:0] master_latency_value;
    logic          pci_frame_in_prev, pci_irdy_in_prev, pci_devsel_in_prev;
    logic          pci_trdy_in_prev, pci_stop_in_prev;
    logic [31:0]   pci_ad_in_prev;
    logic          pci_frame_out_next, pci_irdy_out_next, pci_frame_out_oe_next;
    logic          pci_irdy_out_oe_next, pci_ad_out_oe_next, pci_cbe_out_oe_next;
    logic [31:0]   pci_ad_out_next;
    logic [3:0]    pci_cbe_l_out_next;

    pci_blue_master_seq #(.ABORT_CYCLES(5), .LEN_WIDTH(LW), .LAT_WIDTH(TW)) dut (
        .pci_clk(pci_clk), .pci_reset_comb(pci_reset_comb),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_byte_en_l(wr_byte_en_l), .wr_valid(wr_valid),
        .wr_taken(wr_taken), .rd_data(rd_data), .rd_strobe(rd_strobe),
        .done(done), .done_status(done_status), .done_count(done_count),
        .master_req_out(master_req_out), .master_gnt_now(master_gnt_now),
        .master_enable(master_enable), .master_latency_value(master_latency_value),
        .pci_frame_in_prev(pci_frame_in_prev), .pci_irdy_in_prev(pci_irdy_in_prev),
        .pci_devsel_in_prev(pci_devsel_in_prev), .pci_trdy_in_prev(pci_trdy_in_prev),
        .pci_stop_in_prev(pci_stop_in_prev), .pci_ad_in_prev(pci_ad_in_prev),
        .pci_frame_out_next(pci_frame_out_next), .pci_irdy_out_next(pci_irdy_out_next),
        .pci_frame_out_oe_next(pci_frame_out_oe_next),
        .pci_irdy_out_oe_next(pci_irdy_out_oe_next),
        .pci_ad_out_oe_next(pci_ad_out_oe_next), .pci_cbe_out_oe_next(pci_cbe_out_oe_next),
        .pci_ad_out_next(pci_ad_out_next), .pci_cbe_l_out_next(pci_cbe_l_out_next)
    );

    always #5 pci_clk = ~pci_clk;

    int n_chk = 0;
    int n_fail = 0;

    int t_devsel, t_wait, t_stop_word, t_stop_trdy, t_drop_gnt;
    int t_words, t_waitc, t_term, t_seen;
    int m_wr, m_rd, m_frame_ph, m_bad, m_done, m_stat, m_cnt, m_rdy_done;
    logic        m_wrcmd;
    logic [31:0] m_addr_ad;
    logic [3:0]  m_addr_cbe;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: target drives at negedge, outputs sampled 2 ns later.
    task automatic tick();
        logic dph;
        @(negedge pci_clk);
        dph = pci_irdy_out_oe_next && pci_irdy_out_next;
        wr_data = 32'hD000_0000 + 32'(m_wr);
        if (dph) t_seen = 1;
        master_gnt_now     = !(t_drop_gnt != 0 && t_seen != 0);
        pci_devsel_in_prev = 1'b0;
        pci_trdy_in_prev   = 1'b0;
        pci_stop_in_prev   = 1'b0;
        pci_ad_in_prev     = 32'h0;
        if (dph && t_term == 0) begin
            pci_devsel_in_prev = (t_devsel != 0);
            if (t_waitc >= t_wait) begin
                t_waitc = 0;
                if (t_stop_word == t_words + 1) begin
                    pci_stop_in_prev = 1'b1;
                    pci_trdy_in_prev = (t_stop_trdy != 0);
                    t_term = 1;
                end else begin
                    pci_trdy_in_prev = 1'b1;
                end
                if (pci_trdy_in_prev) begin
                    t_words++;
                    pci_ad_in_prev = 32'hA000_0000 + 32'(t_words);
                end
            end else begin
                t_waitc++;
            end
        end
        #2;
        if (pci_irdy_out_oe_next && pci_frame_out_next && !pci_irdy_out_next) begin
            m_addr_ad  = pci_ad_out_next;
            m_addr_cbe = pci_cbe_l_out_next;
        end
        if (dph) begin
            if (pci_frame_out_next) m_frame_ph++;
            if (pci_cbe_l_out_next != (m_wrcmd ? 4'h3 : 4'h0) ||
                pci_ad_out_oe_next != m_wrcmd || !pci_cbe_out_oe_next) m_bad++;
        end
        if (wr_taken) begin
            if (pci_ad_out_next != 32'hD000_0000 + 32'(m_wr)) m_bad++;
            m_wr++;
        end
        if (rd_strobe) begin
            if (rd_data != 32'hA000_0000 + 32'(m_rd + 1)) m_bad++;
            m_rd++;
        end
        if (done) begin
            m_done++;
            m_stat     = int'(done_status);
            m_cnt      = int'(done_count);
            m_rdy_done = int'(cmd_ready);
        end
    endtask

    task automatic start_cmd(input logic [3:0] code, input logic [31:0] addr, input int len,
                             input int devsel, input int waitn, input int stop_word,
                             input int stop_trdy, input int drop_gnt, input int lat);
        t_devsel = devsel; t_wait = waitn; t_stop_word = stop_word;
        t_stop_trdy = stop_trdy; t_drop_gnt = drop_gnt;
        t_words = 0; t_waitc = 0; t_term = 0; t_seen = 0;
        m_wr = 0; m_rd = 0; m_frame_ph = 0; m_bad = 0; m_done = 0;
        m_stat = -1; m_cnt = -1; m_rdy_done = -1;
        m_wrcmd = code[0]; m_addr_ad = 32'h0; m_addr_cbe = 4'h0;
        master_latency_value = TW'(lat);
        @(negedge pci_clk);
        cmd_code = code; cmd_addr = addr; cmd_len = LW'(len);
        cmd_valid = 1'b1;
        #1;
        chk("cmd_ready", {31'h0, cmd_ready}, 32'h1);
        @(posedge pci_clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_burst(input string name, input logic [3:0] code, input logic [31:0] addr,
                             input int len, input int devsel, input int waitn,
                             input int stop_word, input int stop_trdy, input int drop_gnt,
                             input int hold, input int lat, input int exp_stat,
                             input int exp_cnt, input int exp_fph);
        int cyc;
        start_cmd(code, addr, len, devsel, waitn, stop_word, stop_trdy, drop_gnt, lat);
        cyc = 0;
        while (m_done == 0 && cyc < 300) begin
            tick();
            cmd_valid = (hold != 0) && (m_frame_ph > 0);
            cyc++;
        end
        if (m_done == 0) chk({name, "_timeout"}, 32'h0, 32'h1);
        chk({name, "_status"}, m_stat, exp_stat);
        chk({name, "_count"}, m_cnt, exp_cnt);
        chk({name, "_words"}, m_wrcmd ? m_wr : m_rd, exp_cnt);
        chk({name, "_frame_phases"}, m_frame_ph, exp_fph);
        chk({name, "_addr"}, m_addr_ad, addr);
        chk({name, "_cbe_addr"}, {28'h0, m_addr_cbe}, {28'h0, code});
        chk({name, "_data_bus"}, m_bad, 0);
        tick();
        chk({name, "_done_pulses"}, m_done, 1);
        if (hold != 0) begin
            chk({name, "_no_b2b"}, m_rdy_done, 0);
            #1;
            chk({name, "_idle_accept"}, {31'h0, cmd_ready}, 32'h1);
            cmd_valid = 1'b0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        pci_reset_comb = 1'b1;
        cmd_valid = 1'b0; cmd_code = 4'h0; cmd_addr = 32'h0; cmd_len = '0;
        wr_data = 32'h0; wr_byte_en_l = 4'h3; wr_valid = 1'b1;
        master_gnt_now = 1'b1; master_enable = 1'b1; master_latency_value = 8'hFF;
        pci_frame_in_prev = 1'b0; pci_irdy_in_prev = 1'b0; pci_devsel_in_prev = 1'b0;
        pci_trdy_in_prev = 1'b0; pci_stop_in_prev = 1'b0; pci_ad_in_prev = 32'h0;
        t_devsel = 0; t_wait = 0; t_stop_word = 0; t_stop_trdy = 0; t_drop_gnt = 0;
        t_words = 0; t_waitc = 0; t_term = 0; t_seen = 0;
        m_wr = 0; m_rd = 0; m_frame_ph = 0; m_bad = 0; m_done = 0;
        m_stat = 0; m_cnt = 0; m_rdy_done = 0; m_wrcmd = 1'b0;
        m_addr_ad = 32'h0; m_addr_cbe = 4'h0;

        repeat (2) @(negedge pci_clk);
        #1;
        chk("rst_ctl", {21'h0, cmd_ready, wr_taken, rd_strobe, done, master_req_out,
                        pci_frame_out_next, pci_irdy_out_next, pci_frame_out_oe_next,
                        pci_irdy_out_oe_next, pci_ad_out_oe_next, pci_cbe_out_oe_next}, 32'h0);
        chk("rst_ad", pci_ad_out_next, 32'h0);
        chk("rst_cbe_stat", {25'h0, pci_cbe_l_out_next, done_status}, 32'h0);
        pci_reset_comb = 1'b0;

        //        name      code               addr          len dsel wait stop strdy gnt hold lat  status            cnt fph
        run_burst("wr4",    PCI_CMD_MEM_WRITE, 32'h1000_0000, 4, 1,   0,   0,   0,    0,  0,   255, int'(ST_OK),        4, 3);
        run_burst("rd3",    PCI_CMD_MEM_READ,  32'h2000_0040, 3, 1,   2,   0,   0,    0,  1,   255, int'(ST_OK),        3, 6);
        run_burst("mabort", PCI_CMD_MEM_WRITE, 32'h3000_0000, 4, 0, 1000,  0,   0,    0,  0,   255, int'(ST_MASTER_ABORT),0, 5);
        run_burst("retry",  PCI_CMD_MEM_READ,  32'h4000_0000, 4, 1,   0,   1,   0,    0,  0,   255, int'(ST_RETRY),     0, 1);
        run_burst("disc",   PCI_CMD_MEM_WRITE, 32'h5000_0000, 8, 1,   0,   2,   1,    0,  0,   255, int'(ST_DISCONNECT),2, 2);
        run_burst("tabort", PCI_CMD_MEM_READ,  32'h6000_0000, 2, 0,   0,   1,   0,    0,  0,   255, int'(ST_TARGET_ABORT),0, 1);
        run_burst("latexp", PCI_CMD_MEM_READ,  32'h7000_0000,16, 1,   0,   0,   0,    1,  0,   2,   int'(ST_OK),        4, 3);
        run_burst("len0",   PCI_CMD_MEM_READ,  32'h8000_0000, 0, 1,   0,   0,   0,    0,  0,   255, int'(ST_OK),        1, 0);

        // Reset in the middle of a write burst (target never asserts TRDY).
        start_cmd(PCI_CMD_MEM_WRITE, 32'h9000_0000, 8, 1, 1000, 0, 0, 0, 255);
        cyc = 0;
        while (m_frame_ph < 3 && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("mid_oes_on", {28'h0, pci_frame_out_oe_next, pci_irdy_out_oe_next,
                           pci_ad_out_oe_next, pci_cbe_out_oe_next}, 32'hF);
        #1;
        pci_reset_comb = 1'b1;
        #1;
        chk("mid_rst_out", {23'h0, pci_frame_out_oe_next, pci_irdy_out_oe_next,
                            pci_ad_out_oe_next, pci_cbe_out_oe_next, pci_frame_out_next,
                            pci_irdy_out_next, master_req_out, wr_taken, done}, 32'h0);
        repeat (2) begin
            @(negedge pci_clk);
            #1;
            chk("mid_rst_no_done", {31'h0, done}, 32'h0);
        end
        pci_reset_comb = 1'b0;
        @(negedge pci_clk);
        cmd_valid = 1'b1;
        #1;
        chk("post_rst_idle", {30'h0, cmd_ready, master_req_out}, 32'h2);
        cmd_valid = 1'b0;
        repeat (2) @(negedge pci_clk);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/pci_blue_master_seq.md
Name: pci_blue_master_seq

Overview:
Parametrised PCI master sequencer, next generation of the pci_blue master state machine. Takes one burst command at a time (command, address, length) and runs it on PCI: REQ/GNT, address phase, data phases with IRDY wait states, latency-timer expiry, master-abort timeout, and all target terminations. It reports a completion status to the Target/Response-FIFO side. Sits between the Request FIFO unloader and the pad ring.

Parameters:
ABORT_CYCLES, 5, cycles after the address phase with no DEVSEL before master abort (min 5).
LEN_WIDTH, 5, width of burst-length/word counters; max burst = 2^LEN_WIDTH-1 words.
LAT_WIDTH, 8, latency timer width.

Ports:
pci_clk  in  1  PCI clock
pci_reset_comb  in  1  reset
cmd_valid  in  1  command available
cmd_ready  out  1  command accepted this cycle
cmd_code  in  4  PCI command
cmd_addr  in  32  start address
cmd_len  in  LEN_WIDTH  words to move, 0 illegal (treated as 1)
wr_data  in  32  write data; wr_byte_en_l in 4 byte enables (active low)
wr_valid  in  1  write data present
wr_taken  out  1  write word transferred this cycle
rd_data  out  32  read data; rd_strobe out 1 read word valid
done  out  1  one-cycle completion pulse
done_status  out  3  0 OK, 1 RETRY, 2 DISCONNECT, 3 TARGET_ABORT, 4 MASTER_ABORT
done_count  out  LEN_WIDTH  words transferred
master_req_out  out  1; master_gnt_now  in  1
master_enable  in  1; master_latency_value  in  LAT_WIDTH
pci_frame_in_prev, pci_irdy_in_prev, pci_devsel_in_prev, pci_trdy_in_prev, pci_stop_in_prev  in  1 each
pci_ad_in_prev  in  32
pci_frame_out_next, pci_irdy_out_next, pci_frame_out_oe_next, pci_irdy_out_oe_next, pci_ad_out_oe_next, pci_cbe_out_oe_next  out  1 each
pci_ad_out_next  out  32; pci_cbe_l_out_next  out  4

Behaviour:
- Clock pci_clk; reset pci_reset_comb, asynchronous, active-high.
- All PCI control inputs/outputs: 1 = asserted (pad inverts). All outputs 0 at reset; state IDLE. Reset mid-burst releases all OEs immediately.
- States: IDLE, REQ, ADDR, DATA, LAST, TURN_AR. One-hot encoding.
- IDLE: cmd_valid & master_enable -> REQ, master_req_out=1, latch cmd, cmd_ready pulse.
- REQ: gnt & !frame_in_prev & !irdy_in_prev -> ADDR. Drive frame=1, ad=addr, cbe=cmd, all OEs on.
- ADDR -> DATA (or LAST if len==1). Load latency timer = master_latency_value; abort counter = 0; drop master_req_out when remaining==1.
- DATA/LAST: irdy asserted only when write data valid (reads: always). Transfer = irdy & trdy_in_prev. Each transfer decrements remaining, increments count; read data on rd_strobe, write word acked on wr_taken.
- LAST: frame=0, irdy=1 until final transfer or termination.
- Go to LAST when remaining==1 after the next transfer, or latency timer ==0 & !gnt.
- Termination priority (sampled each data cycle): stop & !devsel -> TARGET_ABORT; no devsel for ABORT_CYCLES after ADDR -> MASTER_ABORT; stop & !trdy -> RETRY if count==0 else DISCONNECT; stop & trdy -> DISCONNECT (word counts); final transfer -> OK. On any termination drop frame (if still up) then irdy the next cycle.
- TURN_AR: one cycle, all OEs off, done pulse with status/count, -> IDLE.
- Latency timer saturates at 0; wraps never.
- Simultaneous cmd_valid in TURN_AR is not accepted until IDLE (no fast back-to-back).
- ad OE off during read data phases; cbe carries wr_byte_en_l on writes, 4'h0 on reads.

Decomposition:
- pci_blue_constants package: command codes, done_status encodings, state one-hot constants.
- One sub-module: pci_blue_master_timers (latency timer + abort counter, load/decrement/expired flags).

Test Plan:
- Write 4 words, target TRDY every cycle -> 4 wr_taken, frame drops with word 4, done OK count 4.
- Read 3 words, TRDY delayed 2 cycles/word -> rd_data matches 3 words, done OK count 3.
- No DEVSEL -> frame drops at ABORT_CYCLES=5, done MASTER_ABORT count 0.
- STOP with no TRDY on first phase -> done RETRY count 0; STOP+TRDY on word 2 of 8 -> DISCONNECT count 2.
- latency_value=2, GNT removed, len 16 -> LAST after timer expiry, done OK count <16 reported exactly.
- Reset asserted during DATA -> all OEs 0 same cycle, state IDLE, no done pulse.
